// File: rtl/cardinal_ring_arb.sv
`default_nettype none
// ============================================================================
// cardinal_ring_arb : ring output-port arbiter, two one-entry VCs with
//                     polarity-phased drain/fill and round-robin grants.
// Revision: 1.0
// ============================================================================
module cardinal_ring_arb #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              polarity,
  input  logic              fwd_si,
  output logic              fwd_ri,
  input  logic [DATA_W-1:0] fwd_di,
  input  logic              pe_si,
  output logic              pe_ri,
  input  logic [DATA_W-1:0] pe_di,
  output logic              dn_so,
  input  logic              dn_ri,
  output logic [DATA_W-1:0] dn_do,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [CNT_W-1:0]  pe_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [1:0][DATA_W-1:0] r_buf;
  logic [1:0]             r_full;
  logic                   r_ptr;     // 0: fwd owns the tie, 1: pe owns the tie

  logic w_fill;
  logic w_fwd_elig;
  logic w_pe_elig;

  // The VC being drained this cycle is never offered to requesters.
  assign w_fill     = ~polarity;
  assign w_fwd_elig = fwd_si && (fwd_di[0] == w_fill) && !r_full[w_fill];
  assign w_pe_elig  = pe_si  && (pe_di[0]  == w_fill) && !r_full[w_fill];

  always_comb begin
    fwd_ri = 1'b0;
    pe_ri  = 1'b0;
    if (w_fwd_elig && (!w_pe_elig || !r_ptr)) begin
      fwd_ri = 1'b1;
    end else if (w_pe_elig) begin
      pe_ri = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      polarity <= 1'b0;
      r_buf    <= '0;
      r_full   <= 2'b00;
      r_ptr    <= 1'b0;
      dn_so    <= 1'b0;
      dn_do    <= '0;
      fwd_cnt  <= '0;
      pe_cnt   <= '0;
    end else begin
      polarity <= ~polarity;

      if (r_full[polarity] && dn_ri) begin
        dn_so            <= 1'b1;
        dn_do            <= r_buf[polarity];
        r_full[polarity] <= 1'b0;
      end else begin
        dn_so <= 1'b0;
      end

      // Pointer always moves to the requester that did not win.
      if (fwd_ri) begin
        r_buf[w_fill]  <= fwd_di;
        r_full[w_fill] <= 1'b1;
        r_ptr          <= 1'b1;
        if (fwd_cnt != C_CNT_MAX) fwd_cnt <= fwd_cnt + CNT_W'(1);
      end else if (pe_ri) begin
        r_buf[w_fill]  <= pe_di;
        r_full[w_fill] <= 1'b1;
        r_ptr          <= 1'b0;
        if (pe_cnt != C_CNT_MAX) pe_cnt <= pe_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_ring_arb.sv
`default_nettype none
// ============================================================================
// tb_cardinal_ring_arb : directed bench with a behavioural reference model.
// Revision: 1.0
// ============================================================================
module tb_cardinal_ring_arb;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 8;   // narrow counters so saturation is reachable quickly
  localparam int C_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              polarity;
  logic              fwd_si, fwd_ri, pe_si, pe_ri, dn_so, dn_ri;
  logic [DATA_W-1:0] fwd_di, pe_di, dn_do;
  logic [CNT_W-1:0]  fwd_cnt, pe_cnt;

  cardinal_ring_arb #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .fwd_si(fwd_si), .fwd_ri(fwd_ri), .fwd_di(fwd_di),
    .pe_si(pe_si), .pe_ri(pe_ri), .pe_di(pe_di),
    .dn_so(dn_so), .dn_ri(dn_ri), .dn_do(dn_do),
    .fwd_cnt(fwd_cnt), .pe_cnt(pe_cnt)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;
  logic [DATA_W-1:0] sent[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                m_pol, m_so, m_ptr;   // m_ptr: 0 = fwd holds priority
  bit                m_full[2];
  logic [DATA_W-1:0] m_buf[2];
  logic [DATA_W-1:0] m_do;
  int                m_fc, m_pc;

  bit                n_pol, n_so, n_ptr;
  bit                n_full[2];
  logic [DATA_W-1:0] n_buf[2];
  logic [DATA_W-1:0] n_do;
  int                n_fc, n_pc;

  always @(negedge clk) begin
    int  fill, winner;
    bit  ef, ep;
    fill = m_pol ? 0 : 1;
    ef = fwd_si && (int'(fwd_di[0]) == fill) && !m_full[fill];
    ep = pe_si  && (int'(pe_di[0])  == fill) && !m_full[fill];
    winner = 0;
    if (ef && ep) winner = m_ptr ? 2 : 1;
    else if (ef)  winner = 1;
    else if (ep)  winner = 2;

    if (chk_en) begin
      chk("polarity", polarity, m_pol);
      chk("fwd_ri", fwd_ri, winner == 1);
      chk("pe_ri", pe_ri, winner == 2);
      chk("dn_so", dn_so, m_so);
      chk("dn_do", dn_do, m_do);
      chk("fwd_cnt", fwd_cnt, m_fc);
      chk("pe_cnt", pe_cnt, m_pc);
      if (dn_so) sent.push_back(dn_do);
    end

    n_pol  = !m_pol;
    n_full = m_full;
    n_buf  = m_buf;
    n_ptr  = m_ptr;
    n_fc   = m_fc;
    n_pc   = m_pc;
    n_so   = m_full[m_pol] && dn_ri;
    n_do   = n_so ? m_buf[m_pol] : m_do;
    if (n_so) n_full[m_pol] = 1'b0;
    if (winner != 0) begin
      n_buf[fill]  = (winner == 1) ? fwd_di : pe_di;
      n_full[fill] = 1'b1;
      n_ptr        = (winner == 1);
      if (winner == 1) n_fc = (m_fc < C_MAX) ? m_fc + 1 : C_MAX;
      else             n_pc = (m_pc < C_MAX) ? m_pc + 1 : C_MAX;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pol <= 1'b0; m_so <= 1'b0; m_ptr <= 1'b0; m_do <= '0;
      m_full <= '{1'b0, 1'b0}; m_buf <= '{'0, '0};
      m_fc <= 0; m_pc <= 0;
    end else begin
      m_pol <= n_pol; m_so <= n_so; m_ptr <= n_ptr; m_do <= n_do;
      m_full <= n_full; m_buf <= n_buf;
      m_fc <= n_fc; m_pc <= n_pc;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit f_hs, p_hs;

  task automatic neg();
    @(negedge clk);
    f_hs = fwd_si && fwd_ri;
    p_hs = pe_si && pe_ri;
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
    if (f_hs) fwd_si = 1'b0;
    if (p_hs) pe_si  = 1'b0;
    f_hs = 1'b0;
    p_hs = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin neg(); pos(); end
  endtask

  task automatic align(input bit v);
    do tick(1); while (m_pol != v);
  endtask

  localparam logic [63:0] PKT_T2 = 64'h8000_0000_0000_00AB;
  localparam logic [63:0] PKT_F3 = 64'h0123_4567_89AB_CDE1;
  localparam logic [63:0] PKT_P3 = 64'hFEDC_BA98_7654_3211;
  localparam logic [63:0] PKT_A  = 64'hA5A5_0000_1111_0001;
  localparam logic [63:0] PKT_B  = 64'hB6B6_0000_2222_0003;
  localparam logic [63:0] PKT_C  = 64'hC7C7_0000_3333_0004;
  localparam logic [63:0] PKT_E5 = 64'h5555_AAAA_0000_1230;
  localparam logic [63:0] PKT_D  = 64'hDDDD_0000_4444_0005;
  localparam logic [63:0] PKT_E  = 64'hEEEE_0000_5555_0006;

  initial begin
    int budget;
    reset = 1'b1; dn_ri = 1'b0;
    fwd_si = 1'b0; fwd_di = '0; pe_si = 1'b0; pe_di = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("t1_pol", polarity, i % 2);
      chk("t1_so", dn_so, 0);
      chk("t1_ri", {fwd_ri, pe_ri}, 0);
      chk("t1_cnt", {fwd_cnt, pe_cnt}, 0);
      pos();
    end

    // 2: single injection, two-cycle latency
    align(0);
    pe_si = 1'b1; pe_di = PKT_T2; dn_ri = 1'b1;
    neg(); chk("t2_pe_ri", pe_ri, 1); pos();
    neg(); chk("t2_so_t1", dn_so, 0); pos();
    neg(); chk("t2_so_t2", dn_so, 1); chk("t2_do", dn_do, PKT_T2); pos();
    neg(); chk("t2_so_t3", dn_so, 0); chk("t2_pe_cnt", pe_cnt, 1); pos();

    // 3: contention on VC1, pointer at fwd
    align(0);
    fwd_si = 1'b1; fwd_di = PKT_F3; pe_si = 1'b1; pe_di = PKT_P3;
    neg(); chk("t3_fwd_first", {fwd_ri, pe_ri}, 2'b10); pos();
    neg(); chk("t3_pe_wait", pe_ri, 0); pos();
    neg(); chk("t3_pe_second", pe_ri, 1); chk("t3_do_fwd", dn_do, PKT_F3); pos();
    neg(); pos();
    neg(); chk("t3_do_pe", dn_do, PKT_P3); chk("t3_cnts", {fwd_cnt, pe_cnt}, {8'd1, 8'd2}); pos();

    // 4: backpressure with VC1 full
    dn_ri = 1'b0;
    align(0);
    fwd_si = 1'b1; fwd_di = PKT_A;
    neg(); chk("t4_fill_a", fwd_ri, 1); pos();
    pe_si = 1'b1; pe_di = PKT_B; fwd_si = 1'b1; fwd_di = PKT_C;
    for (int i = 0; i < 6; i++) begin
      neg(); chk("t4_so_stall", dn_so, 0); chk("t4_vc1_blocked", pe_ri, 0); pos();
    end
    chk("t4_vc0_accepted", fwd_si, 0);
    align(0);
    sent.delete();
    dn_ri = 1'b1;
    budget = 0;
    while (sent.size() < 3 && budget < 20) begin tick(1); budget++; end
    chk("t4_count", sent.size(), 3);
    if (sent.size() >= 3) begin
      chk("t4_first", sent[0], PKT_C);
      chk("t4_second", sent[1], PKT_A);
      chk("t4_third", sent[2], PKT_B);
    end

    // 5: wrong-phase request waits one cycle
    align(0);
    pe_si = 1'b1; pe_di = PKT_E5;
    neg(); chk("t5_wrong_phase", pe_ri, 0); pos();
    neg(); chk("t5_next_phase", pe_ri, 1); pos();
    tick(2);

    // 6: counter saturation, then reset with both buffers full
    fwd_di = PKT_A;
    for (int i = 0; i < 600; i++) begin
      if (!fwd_si) fwd_si = 1'b1;
      tick(1);
    end
    fwd_si = 1'b0;
    chk("t6_saturated", fwd_cnt, C_MAX);
    tick(4);
    dn_ri = 1'b0;
    align(0);
    fwd_si = 1'b1; fwd_di = PKT_D;
    tick(1);
    pe_si = 1'b1; pe_di = PKT_E;
    tick(1);
    chk("t6_granted", {fwd_si, pe_si}, 2'b00);
    tick(1);
    sent.delete();
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_pol", polarity, 0);
    chk("t6_rst_so", dn_so, 0);
    chk("t6_rst_do", dn_do, 0);
    chk("t6_rst_cnt", {fwd_cnt, pe_cnt}, 0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    dn_ri = 1'b1;
    tick(8);
    chk("t6_no_emit", sent.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
